quad_encoder_emulator: RTL and testbench
========================================

# quad_encoder_emulator

Generates quadrature A/B/index signals that mimic an incremental optical encoder, stepping an internal count toward a commanded target position at a programmable edge rate. It is the encoder-side counterpart of the quadrature counter on the motor board. It drives the encoder input pins in hardware-in-the-loop and bench setups, so the motor controller and coms path can be exercised without a spinning motor.

## Interface
- CPR, default 2048: encoder counts per revolution; the index pulse repeats every CPR counts (must be ≥4).
- PERIOD_W, default 16: width of the edge-period input.

- CLK  in  1  system clock (16 MHz on board); all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset; deasserted synchronously to CLK.
- enable  in  1  when low, stepping halts and outputs hold their current values.
- target  in  32  signed target count (two's complement).
- period  in  PERIOD_W  CLK cycles between successive count edges; 0 behaves as 1.
- quadA  out  1  encoder channel A.
- quadB  out  1  encoder channel B.
- index  out  1  index (Z) channel.
- position  out  32  signed count currently represented on A/B.
- busy  out  1  high while position ≠ target and enable is high.

## Operation
- Internal state: position (32b signed), divider counter (PERIOD_W bits), index counter idx (0..CPR-1), FSM.
- FSM states:
  - IDLE: position == target or enable low. On entering WAIT, the divider loads max(period,1)-1.
  - WAIT: counts the divider down. At 0, go to STEP.
  - STEP: one cycle. Compare target to position using a 33-bit signed difference, so there is no overflow.
    - target > position: position +1; idx +1, wrapping CPR-1 → 0.
    - target < position: position −1; idx −1, wrapping 0 → CPR-1.
    - equal (target changed mid-interval): no step.
    - Then return to WAIT if still unequal, else IDLE.
- Direction is re-evaluated at every STEP. A target reversal mid-motion simply reverses the next step; no step is skipped or doubled.
- Quadrature mapping from position[1:0]:
  - 00 → A=0,B=0; 01 → A=1,B=0; 10 → A=1,B=1; 11 → A=0,B=1.
  - Increasing position means A leads B. This is the positive-count direction of the board's quad counter.
  - Exactly one of A/B toggles per step, so the output is Gray-coded.
- index = 1 iff idx == 0. It is one count wide.
- enable low: FSM goes to IDLE and the divider clears. On re-enable, the first step comes a full period later.
- period is sampled only when the divider loads; changes mid-interval take effect on the next interval.
- Position 32-bit wrap cannot occur, because position only moves toward a representable target.

## Timing
- Reset values:
  - position=0, idx=0, FSM=IDLE, divider=0.
  - quadA=0, quadB=0, index=1 (idx==0), busy=0.
- All outputs are registered. quadA/quadB/index/position change on the same CLK edge as the STEP update.
- Latency:
  - target change while IDLE → busy high on the next edge.
  - First A/B edge occurs max(period,1)+1 cycles after target is sampled.
  - Subsequent edges are spaced exactly max(period,1)+1 cycles apart (WAIT + STEP).
  - Minimum spacing is 2 cycles at period ≤ 1.
- busy falls on the edge where position reaches target.
- Reset asserted mid-motion: all state returns to reset values immediately (async), with no partial step.

## Structure
- Shared package: quadrature phase encoding constants (A/B per position[1:0]), FSM state enum, default CPR.
- One sub-module, quad_phase_gen: combinational position[1:0] → {A,B} plus output registers. It is reusable by a future hall-sensor emulator.
- The index counter and FSM stay in the top module.

## Test plan
- Reset release, target=0 → quadA=quadB=0, index=1, busy=0, no edges over 1000 cycles.
- target=+5, period=3 → 5 steps, 4 cycles apart; A/B sequence 10,11,01,00,10; position=5; busy falls on the 5th step.
- target=−3 from 0, period=1 → B leads A (01,11,10); position=−3; index high only at start, since idx goes 0→2047→2046→2045.
- CPR=8, target=+17, period=0 → index pulses exactly when position=8 and 16, each one count wide; steps 2 cycles apart.
- At position=3 heading to +10, set target=−1 mid-WAIT → next step goes to 2; no repeated or skipped Gray code; ends at −1.
- Assert reset during motion at position=7; also drop enable at position=4 → reset: all outputs at reset values immediately. Enable: A/B frozen, busy=0; resumes one full period after enable returns high.

Source files
------------

// File: rtl/quad_encoder_emulator_pkg.sv
// Shared definitions for the quadrature encoder emulator: phase encoding,
// FSM states and default resolution.
package quad_encoder_emulator_pkg;

  localparam int DEFAULT_CPR = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STEP
  } state_t;

  // {A,B} for each value of position[1:0]; increasing position means A leads B.
  localparam logic [1:0] AB_PH0 = 2'b00;
  localparam logic [1:0] AB_PH1 = 2'b10;
  localparam logic [1:0] AB_PH2 = 2'b11;
  localparam logic [1:0] AB_PH3 = 2'b01;

  function automatic logic [1:0] phase_ab(input logic [1:0] ph);
    logic [1:0] ab;
    case (ph)
      2'd0:    ab = AB_PH0;
      2'd1:    ab = AB_PH1;
      2'd2:    ab = AB_PH2;
      default: ab = AB_PH3;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// Maps a two-bit phase to Gray-coded quadrature levels and registers them.
// Fed with the next-state phase so A/B change on the same edge as the count.
module quad_phase_gen
  import quad_encoder_emulator_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] phase,
  output logic       quadA,
  output logic       quadB
);

  logic [1:0] ab;

  assign ab = phase_ab(phase);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      {quadA, quadB} <= AB_PH0;
    end else begin
      {quadA, quadB} <= ab;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Incremental encoder emulator: steps position toward target one count per
// period and drives quadrature A/B plus a once-per-revolution index pulse.
module quad_encoder_emulator
  import quad_encoder_emulator_pkg::*;
#(
  parameter int CPR      = DEFAULT_CPR,
  parameter int PERIOD_W = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic signed [31:0]  target,
  input  logic [PERIOD_W-1:0] period,
  output logic                quadA,
  output logic                quadB,
  output logic                index,
  output logic signed [31:0]  position,
  output logic                busy
);

  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CPR - 1);

  state_t                state;
  logic [PERIOD_W-1:0]   div;
  logic [PERIOD_W-1:0]   div_load;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic signed [31:0]    pos_nxt;
  logic signed [32:0]    diff;

  // One extra bit keeps the direction decision correct across the full range.
  assign diff     = {target[31], target} - {position[31], position};
  assign div_load = (period == '0) ? '0 : period - 1'b1;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    pos_nxt = position;
    idx_nxt = idx;
    if (state == ST_STEP && enable) begin
      if (diff > 33'sd0) begin
        pos_nxt = position + 32'sd1;
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (diff < 33'sd0) begin
        pos_nxt = position - 32'sd1;
        idx_nxt = (idx == '0) ? IDX_LAST : idx - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      div      <= '0;
      position <= '0;
      idx      <= '0;
      index    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      position <= pos_nxt;
      idx      <= idx_nxt;
      index    <= (idx_nxt == '0);
      busy     <= enable && (pos_nxt != target);
      if (!enable) begin
        state <= ST_IDLE;
        div   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (target != position) begin
              state <= ST_WAIT;
              div   <= div_load;
            end
          end
          ST_WAIT: begin
            if (div == '0) state <= ST_STEP;
            else           div   <= div - 1'b1;
          end
          ST_STEP: begin
            if (pos_nxt != target) begin
              state <= ST_WAIT;
              div   <= div_load;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  quad_phase_gen u_phase (
    .CLK   (CLK),
    .reset (reset),
    .phase (pos_nxt[1:0]),
    .quadA (quadA),
    .quadB (quadB)
  );

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: default-CPR instance plus a CPR=8
// instance for index wrap behaviour.
module tb_quad_encoder_emulator;

  logic               CLK = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [31:0] target = 32'sd0;
  logic signed [31:0] target8 = 32'sd0;
  logic [15:0]        period = 16'd0;

  logic               quadA, quadB, index, busy;
  logic signed [31:0] position;
  logic               quadA8, quadB8, index8, busy8;
  logic signed [31:0] position8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  quad_encoder_emulator dut (
    .CLK      (CLK),
    .reset    (reset),
    .enable   (enable),
    .target   (target),
    .period   (period),
    .quadA    (quadA),
    .quadB    (quadB),
    .index    (index),
    .position (position),
    .busy     (busy)
  );

  quad_encoder_emulator #(.CPR(8), .PERIOD_W(16)) dut8 (
    .CLK      (CLK),
    .reset    (reset),
    .enable   (enable),
    .target   (target8),
    .period   (period),
    .quadA    (quadA8),
    .quadB    (quadB8),
    .index    (index8),
    .position (position8),
    .busy     (busy8)
  );

  function automatic logic [1:0] ab_of(input logic signed [31:0] p);
    logic [1:0] ph;
    ph = p[1:0];
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Waits (bounded) for the selected instance's position to change.
  task automatic wait_move(input bit sel8, input int budget, output int cyc, output bit ok);
    logic signed [31:0] p0;
    p0  = sel8 ? position8 : position;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if ((sel8 ? position8 : position) !== p0) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    target  = 32'sd0;
    target8 = 32'sd0;
    enable  = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int edges;
    logic [1:0] prev;
    #1 reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++; if (position !== 32'sd0) begin n_err++; $display("FAIL reset_pos got=%0d exp=0", position); end
    n_cmp++; if ({quadA, quadB} !== 2'b00) begin n_err++; $display("FAIL reset_ab got=%b exp=00", {quadA, quadB}); end
    n_cmp++; if (index !== 1'b1) begin n_err++; $display("FAIL reset_index got=%b exp=1", index); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    edges = 0;
    prev  = {quadA, quadB};
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if ({quadA, quadB} !== prev) edges++;
      prev = {quadA, quadB};
    end
    n_cmp++; if (edges !== 0) begin n_err++; $display("FAIL idle_edges got=%0d exp=0", edges); end
    n_cmp++; if (busy !== 1'b0 || index !== 1'b1) begin n_err++; $display("FAIL idle_flags busy=%b index=%b exp busy=0 index=1", busy, index); end
  endtask

  task automatic test_plus5();
    logic [1:0] exp_ab [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    int cyc;
    bit ok;
    period = 16'd3;
    target = 32'sd5;
    @(negedge CLK);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL p5_busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= 5; k++) begin
      wait_move(1'b0, 20, cyc, ok);
      n_cmp++; if (!ok || cyc !== 4) begin n_err++; $display("FAIL p5_spacing step=%0d got=%0d exp=4", k, cyc); end
      n_cmp++; if (position !== k) begin n_err++; $display("FAIL p5_pos step=%0d got=%0d exp=%0d", k, position, k); end
      n_cmp++; if ({quadA, quadB} !== exp_ab[k-1]) begin n_err++; $display("FAIL p5_ab step=%0d got=%b exp=%b", k, {quadA, quadB}, exp_ab[k-1]); end
      n_cmp++; if (busy !== (k < 5)) begin n_err++; $display("FAIL p5_busy step=%0d got=%b exp=%b", k, busy, (k < 5)); end
    end
    repeat (30) @(negedge CLK);
    n_cmp++; if (position !== 32'sd5 || busy !== 1'b0) begin n_err++; $display("FAIL p5_settle pos=%0d busy=%b exp pos=5 busy=0", position, busy); end
  endtask

  task automatic test_minus3();
    logic [1:0] exp_ab [3] = '{2'b01, 2'b11, 2'b10};
    int cyc;
    bit ok;
    do_reset();
    period = 16'd1;
    target = -32'sd3;
    @(negedge CLK);
    n_cmp++; if (busy !== 1'b1 || index !== 1'b1) begin n_err++; $display("FAIL m3_start busy=%b index=%b exp 1 1", busy, index); end
    for (int k = 1; k <= 3; k++) begin
      wait_move(1'b0, 10, cyc, ok);
      n_cmp++; if (!ok || cyc !== 2) begin n_err++; $display("FAIL m3_spacing step=%0d got=%0d exp=2", k, cyc); end
      n_cmp++; if (position !== -k) begin n_err++; $display("FAIL m3_pos step=%0d got=%0d exp=%0d", k, position, -k); end
      n_cmp++; if ({quadA, quadB} !== exp_ab[k-1]) begin n_err++; $display("FAIL m3_ab step=%0d got=%b exp=%b", k, {quadA, quadB}, exp_ab[k-1]); end
      n_cmp++; if (index !== 1'b0) begin n_err++; $display("FAIL m3_index step=%0d got=%b exp=0", k, index); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL m3_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_cpr8();
    int cyc;
    bit ok;
    period  = 16'd0;
    target8 = 32'sd17;
    @(negedge CLK);
    n_cmp++; if (index8 !== 1'b1) begin n_err++; $display("FAIL c8_index_start got=%b exp=1", index8); end
    for (int k = 1; k <= 17; k++) begin
      wait_move(1'b1, 10, cyc, ok);
      n_cmp++; if (!ok || cyc !== 2) begin n_err++; $display("FAIL c8_spacing step=%0d got=%0d exp=2", k, cyc); end
      n_cmp++; if (position8 !== k) begin n_err++; $display("FAIL c8_pos step=%0d got=%0d exp=%0d", k, position8, k); end
      n_cmp++; if (index8 !== (k % 8 == 0)) begin n_err++; $display("FAIL c8_index pos=%0d got=%b exp=%b", k, index8, (k % 8 == 0)); end
    end
  endtask

  task automatic test_reversal();
    int cyc;
    bit ok;
    logic [1:0] prev_ab;
    do_reset();
    period = 16'd3;
    target = 32'sd10;
    @(negedge CLK);
    for (int k = 1; k <= 3; k++) begin
      wait_move(1'b0, 20, cyc, ok);
      n_cmp++; if (position !== k) begin n_err++; $display("FAIL rev_fwd step=%0d got=%0d exp=%0d", k, position, k); end
    end
    target = -32'sd1;
    for (int e = 2; e >= -1; e--) begin
      prev_ab = {quadA, quadB};
      wait_move(1'b0, 20, cyc, ok);
      n_cmp++; if (!ok || cyc !== 4) begin n_err++; $display("FAIL rev_spacing pos=%0d got=%0d exp=4", e, cyc); end
      n_cmp++; if (position !== e) begin n_err++; $display("FAIL rev_pos got=%0d exp=%0d", position, e); end
      n_cmp++; if ({quadA, quadB} !== ab_of(e) || $countones({quadA, quadB} ^ prev_ab) !== 1) begin
        n_err++; $display("FAIL rev_gray pos=%0d got=%b prev=%b exp=%b", e, {quadA, quadB}, prev_ab, ab_of(e));
      end
    end
    repeat (20) @(negedge CLK);
    n_cmp++; if (position !== -32'sd1 || busy !== 1'b0) begin n_err++; $display("FAIL rev_end pos=%0d busy=%b exp pos=-1 busy=0", position, busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    do_reset();
    period = 16'd1;
    target = 32'sd10;
    @(negedge CLK);
    for (int k = 1; k <= 7; k++) wait_move(1'b0, 10, cyc, ok);
    n_cmp++; if (position !== 32'sd7) begin n_err++; $display("FAIL rm_pre pos got=%0d exp=7", position); end
    reset = 1'b0;
    #1;
    n_cmp++; if (position !== 32'sd0 || {quadA, quadB} !== 2'b00) begin n_err++; $display("FAIL rm_async pos=%0d ab=%b exp 0 00", position, {quadA, quadB}); end
    n_cmp++; if (index !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rm_flags index=%b busy=%b exp 1 0", index, busy); end
    @(negedge CLK);
    target  = 32'sd0;
    target8 = 32'sd0;
    reset   = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_enable();
    int cyc;
    bit ok;
    do_reset();
    period = 16'd3;
    target = 32'sd10;
    @(negedge CLK);
    for (int k = 1; k <= 4; k++) wait_move(1'b0, 20, cyc, ok);
    enable = 1'b0;
    @(negedge CLK);
    n_cmp++; if (busy !== 1'b0 || position !== 32'sd4 || {quadA, quadB} !== 2'b00) begin
      n_err++; $display("FAIL en_off busy=%b pos=%0d ab=%b exp 0 4 00", busy, position, {quadA, quadB});
    end
    repeat (20) @(negedge CLK);
    n_cmp++; if (position !== 32'sd4 || {quadA, quadB} !== 2'b00) begin n_err++; $display("FAIL en_hold pos=%0d ab=%b exp 4 00", position, {quadA, quadB}); end
    enable = 1'b1;
    wait_move(1'b0, 20, cyc, ok);
    n_cmp++; if (!ok || cyc !== 5) begin n_err++; $display("FAIL en_resume got=%0d exp=5", cyc); end
    n_cmp++; if (position !== 32'sd5 || {quadA, quadB} !== 2'b10 || busy !== 1'b1) begin
      n_err++; $display("FAIL en_step pos=%0d ab=%b busy=%b exp 5 10 1", position, {quadA, quadB}, busy);
    end
  endtask

  initial begin
    test_reset();
    test_plus5();
    test_minus3();
    test_cpr8();
    test_reversal();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
